// File: rtl/adler32_pkg.sv
// Shared definitions for the multi-byte Adler-32 engine: modulus, FSM
// encoding, and the fold-and-subtract reducer used for both accumulators.
// Pure package; no timing or flow-control content.
package adler32_pkg;

    localparam logic [15:0] ADLER_MOD = 16'd65521;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACTV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Exact x mod 65521 for any 24-bit x, using 2^16 == 15 (mod 65521).
    // After the first fold x <= 69360; if bit 16 is then set, the low half is
    // at most 3824, so the second fold lands in 0..65535 and one conditional
    // subtract finishes the job.
    function automatic logic [15:0] fold16(input logic [23:0] x);
        logic [16:0] f1;
        logic [16:0] f2;
        f1 = {1'b0, x[15:0]} + 17'(x[23:16]) * 17'd15;
        f2 = {1'b0, f1[15:0]} + (f1[16] ? 17'd15 : 17'd0);
        if (f2 >= {1'b0, ADLER_MOD}) begin
            fold16 = f2[15:0] - ADLER_MOD;
        end else begin
            fold16 = f2[15:0];
        end
    endfunction

endpackage

// File: rtl/adler32_mod.sv
// Combinational mod-65521 reducer for a raw accumulator sum of up to 24 bits.
// Latency: zero cycles (pure combinational).
// Backpressure: none; no flow control.
// Ports: raw_i - unreduced sum (IN_WD bits); red_o - reduced value 0..65520.
module adler32_mod
    import adler32_pkg::*;
#(
    parameter int IN_WD = 24
) (
    input  logic [IN_WD-1:0] raw_i,
    output logic [15:0]      red_o
);

    logic [23:0] raw_ext;

    assign raw_ext = 24'(raw_i);
    assign red_o   = fold16(raw_ext);

endmodule

// File: rtl/adler32_mb.sv
// Multi-byte Adler-32 engine: BYTES stream bytes per accepted beat, partial last beat.
// Latency: checksum valid (done_o/val_o) one cycle after the final beat is accepted.
// Backpressure: rdy_o high only while a checksum is active; full rate, bubbles hold state.
// Ports: start_i opens a stream; val_i/rdy_o/dat_i/lst_i/bcnt_i carry beats
// (first byte in the MSBs); done_o pulses once, dat_o/val_o hold {s2,s1}.
module adler32_mb
    import adler32_pkg::*;
#(
    parameter  int BYTES   = 4,
    localparam int DATA_WD = 8 * BYTES,
    localparam int CNT_WD  = $clog2(BYTES + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               val_i,
    output logic               rdy_o,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               lst_i,
    input  logic [CNT_WD-1:0]  bcnt_i,
    output logic               done_o,
    output logic               val_o,
    output logic [31:0]        dat_o
);

    localparam logic [CNT_WD-1:0] BYTES_C = CNT_WD'(BYTES);

    state_t            state_q, state_d;
    logic [15:0]       s1_q, s1_d;
    logic [15:0]       s2_q, s2_d;
    logic [31:0]       dat_q, dat_d;
    logic              val_q, val_d;
    logic [CNT_WD-1:0] nb;
    logic [23:0]       raw_s1, raw_s2;
    logic [15:0]       red_s1, red_s2;

    // Byte i of a beat weighs (n - i) in s2: it is summed into s1 before the
    // remaining n-1-i bytes, plus once for itself.
    always_comb begin : raw_sums
        nb = BYTES_C;
        if (lst_i) begin
            nb = (bcnt_i > BYTES_C) ? BYTES_C : bcnt_i;
        end
        raw_s1 = 24'(s1_q);
        raw_s2 = 24'(s2_q) + 24'(nb) * 24'(s1_q);
        for (int i = 0; i < BYTES; i++) begin
            if (24'(i) < 24'(nb)) begin
                raw_s1 = raw_s1 + 24'(dat_i[DATA_WD-1-8*i -: 8]);
                raw_s2 = raw_s2 + (24'(nb) - 24'(i)) * 24'(dat_i[DATA_WD-1-8*i -: 8]);
            end
        end
    end

    adler32_mod #(.IN_WD(24)) u_mod_s1 (.raw_i(raw_s1), .red_o(red_s1));
    adler32_mod #(.IN_WD(24)) u_mod_s2 (.raw_i(raw_s2), .red_o(red_s2));

    // start_i wins over everything, including a beat offered in the same cycle.
    always_comb begin : fsm_next
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dat_d   = dat_q;
        val_d   = val_q;
        if (start_i) begin
            state_d = ST_ACTV;
            s1_d    = 16'd1;
            s2_d    = 16'd0;
            val_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ACTV: begin
                    if (val_i) begin
                        s1_d = red_s1;
                        s2_d = red_s2;
                        if (lst_i) begin
                            state_d = ST_DONE;
                            dat_d   = {red_s2, red_s1};
                            val_d   = 1'b1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            s1_q    <= 16'd0;
            s2_q    <= 16'd0;
            dat_q   <= 32'd0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dat_q   <= dat_d;
            val_q   <= val_d;
        end
    end

    assign rdy_o  = (state_q == ST_ACTV);
    assign done_o = (state_q == ST_DONE);
    assign val_o  = val_q;
    assign dat_o  = dat_q;

endmodule
